// File: rtl/sipo_receiver.sv
// Serial-in / parallel-out receiver.
// A two-state shifter (IDLE / SHIFT) assembles WIDTH serial bits into a word.
// A separate output register (q / valid) gives double buffering. While the
// consumer holds one word, the shifter can assemble the next one.
//
// Output handshake (valid/ready):
//   - valid=1 means q holds a word that has not yet been consumed.
//   - The consumer takes q on any rising edge where valid=1 and ready=1.
//   - Once valid is high, q is stable until that handshake happens.
//     The one exception is a word completing on the same edge as the
//     handshake: q then reloads with the new word and valid stays high.
//   - ready has no effect while valid=0.
//   - If a word completes while valid=1 and ready=0, the new word is
//     dropped and the sticky overrun flag is set.
module sipo_receiver #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     shift_en,
    input  logic                     d,
    input  logic                     clear,
    input  logic                     ready,
    output logic [WIDTH-1:0]         q,
    output logic                     valid,
    output logic                     busy,
    output logic [$clog2(WIDTH)-1:0] bit_count,
    output logic                     overrun
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    // busy is a direct decode of this state and serves as its debug view.
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_d;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] q_q;
    logic             valid_q;
    logic             overrun_q;

    logic             shift_fire;
    logic             word_done;
    logic             handshake;

    // Next shifter contents with the current serial bit inserted at the
    // end selected by the bit order.
    always_comb begin
        sr_d = sr_q;
        if (MSB_FIRST) begin
            sr_d = {sr_q[WIDTH-2:0], d};
        end else begin
            sr_d = {d, sr_q[WIDTH-1:1]};
        end
    end

    // Strobe decode. clear masks shift_en, so an aborted word never
    // completes. A word can only complete from SHIFT, because WIDTH >= 2.
    always_comb begin
        shift_fire = shift_en && !clear;
        word_done  = shift_fire && (state_q == SHIFT) && (cnt_q == LAST_BIT);
        handshake  = valid_q && ready;
    end

    // Shifter FSM, output buffer and overrun flag, all in one register
    // process so that every output is a flop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            sr_q      <= '0;
            cnt_q     <= '0;
            q_q       <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            // Shifter side.
            if (clear) begin
                state_q   <= IDLE;
                cnt_q     <= '0;
                sr_q      <= '0;
                overrun_q <= 1'b0;
            end else if (shift_en) begin
                sr_q <= sr_d;
                case (state_q)
                    IDLE: begin
                        cnt_q   <= CW'(1);
                        state_q <= SHIFT;
                    end
                    SHIFT: begin
                        if (cnt_q == LAST_BIT) begin
                            cnt_q   <= '0;
                            state_q <= IDLE;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                    default: begin
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end
                endcase
            end

            // Output buffer side. A completion takes precedence over a
            // plain handshake because it decides what q holds next.
            if (word_done) begin
                if (!valid_q) begin
                    q_q     <= sr_d;
                    valid_q <= 1'b1;
                end else if (ready) begin
                    q_q <= sr_d;
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (handshake) begin
                valid_q <= 1'b0;
            end
        end
    end

    // Drive the ports from the registered state.
    always_comb begin
        q         = q_q;
        valid     = valid_q;
        busy      = (state_q == SHIFT);
        bit_count = cnt_q;
        overrun   = overrun_q;
    end

endmodule
